// File: rtl/dll_clk_ctrl.sv
// Clock-mode sequencer for the clock-multiplier DLL: applies reset/lock-wait and
// gates the downstream clock enable so mode switches never expose a glitching clock.
module dll_clk_ctrl #(
    parameter int unsigned RST_CYC    = 4,
    parameter int unsigned LOCK_CYC   = 32,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cfg_vld_i,
    output logic       cfg_rdy_o,
    input  logic       cfg_bypass_i,
    input  logic [1:0] cfg_sel_i,
    output logic       dll_rst_o,
    output logic       dll_bypass_o,
    output logic       dll_s1_o,
    output logic       dll_s0_o,
    output logic       clk_en_o,
    output logic       locked_o
);

    // state | meaning
    // BYP   | DLL bypassed, reference clock passed through, requests accepted
    // GOFF  | downstream clock gated off, settling before any pin change
    // RSTH  | DLL out of bypass, held in reset with the new select
    // LOCKW | DLL released from reset, fixed lock wait
    // SETL  | pin changes applied, settling before the clock is re-enabled
    // RUN   | multiplied clock selected and enabled, requests accepted

    localparam int unsigned MAX_AB = (RST_CYC > LOCK_CYC) ? RST_CYC : LOCK_CYC;
    localparam int unsigned MAX_P  = (MAX_AB > SETTLE_CYC) ? MAX_AB : SETTLE_CYC;
    localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] RST_M1    = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] LOCK_M1   = CW'(LOCK_CYC - 1);
    localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_BYP, S_GOFF, S_RSTH, S_LOCKW, S_SETL, S_RUN
    } state_t;

    typedef enum logic [1:0] {
        K_EN, K_SEL, K_BYP
    } kind_t;

    state_t      state_q;
    kind_t       kind_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]  sel_q;
    logic        rdy_q, rst_q, byp_q, s1_q, s0_q, en_q, lock_q;
    logic        hs_d;
    logic        cnt_zero_d;

    assign hs_d       = cfg_vld_i & rdy_q;
    assign cnt_zero_d = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_BYP;
            kind_q  <= K_BYP;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            rdy_q   <= 1'b1;
            rst_q   <= 1'b1;
            byp_q   <= 1'b1;
            s1_q    <= 1'b0;
            s0_q    <= 1'b0;
            en_q    <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            case (state_q)
                S_BYP: begin
                    if (hs_d) begin
                        sel_q <= cfg_sel_i;
                        if (cfg_bypass_i) begin
                            {s1_q, s0_q} <= cfg_sel_i;
                        end else begin
                            kind_q  <= K_EN;
                            state_q <= S_GOFF;
                            cnt_q   <= SETTLE_M1;
                            en_q    <= 1'b0;
                            rdy_q   <= 1'b0;
                            lock_q  <= 1'b0;
                        end
                    end
                end
                S_GOFF: begin
                    if (cnt_zero_d) begin
                        case (kind_q)
                            K_EN: begin
                                state_q      <= S_RSTH;
                                cnt_q        <= RST_M1;
                                byp_q        <= 1'b0;
                                rst_q        <= 1'b1;
                                {s1_q, s0_q} <= sel_q;
                            end
                            K_SEL: begin
                                state_q      <= S_SETL;
                                cnt_q        <= SETTLE_M1;
                                {s1_q, s0_q} <= sel_q;
                            end
                            default: begin
                                state_q <= S_SETL;
                                cnt_q   <= SETTLE_M1;
                                byp_q   <= 1'b1;
                                rst_q   <= 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RSTH: begin
                    if (cnt_zero_d) begin
                        state_q <= S_LOCKW;
                        cnt_q   <= LOCK_M1;
                        rst_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_LOCKW: begin
                    if (cnt_zero_d) begin
                        state_q <= S_SETL;
                        cnt_q   <= SETTLE_M1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SETL: begin
                    if (cnt_zero_d) begin
                        en_q  <= 1'b1;
                        rdy_q <= 1'b1;
                        if (kind_q == K_BYP) begin
                            state_q <= S_BYP;
                        end else begin
                            state_q <= S_RUN;
                            lock_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RUN: begin
                    // A request for the already-selected multiplier is consumed without gating.
                    if (hs_d && (cfg_bypass_i || (cfg_sel_i != sel_q))) begin
                        if (cfg_bypass_i) begin
                            kind_q <= K_BYP;
                        end else begin
                            kind_q <= K_SEL;
                            sel_q  <= cfg_sel_i;
                        end
                        state_q <= S_GOFF;
                        cnt_q   <= SETTLE_M1;
                        en_q    <= 1'b0;
                        rdy_q   <= 1'b0;
                        lock_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_BYP;
                end
            endcase
        end
    end

    assign cfg_rdy_o    = rdy_q;
    assign dll_rst_o    = rst_q;
    assign dll_bypass_o = byp_q;
    assign dll_s1_o     = s1_q;
    assign dll_s0_o     = s0_q;
    assign clk_en_o     = en_q;
    assign locked_o     = lock_q;

endmodule

// File: tb/tb_dll_clk_ctrl.sv
// Directed bench for dll_clk_ctrl: expected per-cycle output snapshots are queued
// when each request is driven and compared cycle by cycle as the DUT responds.
module tb_dll_clk_ctrl;

    localparam int SET = 2;
    localparam int RC  = 4;
    localparam int LC  = 32;
    localparam int TOT = 2 * SET + RC + LC;

    logic       clk, rst_n;
    logic       cfg_vld, cfg_rdy, cfg_bypass;
    logic [1:0] cfg_sel;
    logic       dll_rst, dll_bypass, dll_s1, dll_s0, clk_en, locked;

    dll_clk_ctrl #(.RST_CYC(RC), .LOCK_CYC(LC), .SETTLE_CYC(SET)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cfg_vld_i    (cfg_vld),
        .cfg_rdy_o    (cfg_rdy),
        .cfg_bypass_i (cfg_bypass),
        .cfg_sel_i    (cfg_sel),
        .dll_rst_o    (dll_rst),
        .dll_bypass_o (dll_bypass),
        .dll_s1_o     (dll_s1),
        .dll_s0_o     (dll_s0),
        .clk_en_o     (clk_en),
        .locked_o     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // snapshot layout: {rdy, rst, bypass, s1, s0, clk_en, locked}
    function automatic logic [6:0] vec(logic rdy, logic rst, logic byp, logic [1:0] s,
                                       logic en, logic lk);
        return {rdy, rst, byp, s, en, lk};
    endfunction

    function automatic logic [6:0] obs();
        return {cfg_rdy, dll_rst, dll_bypass, dll_s1, dll_s0, clk_en, locked};
    endfunction

    task automatic check(string tag, logic [6:0] o, logic [6:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic push(string tag, logic [6:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: observed %b expected <none>", obs());
        end else begin
            e = sb.pop_front();
            check(e.tag, obs(), e.v);
        end
    endtask

    task automatic step_check();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic run_sb();
        while (sb.size() > 0) begin
            step_check();
            cfg_vld = 1'b0;
        end
    endtask

    task automatic hs(logic byp, logic [1:0] sel);
        cfg_vld    = 1'b1;
        cfg_bypass = byp;
        cfg_sel    = sel;
    endtask

    task automatic push_enable(string tag, logic [1:0] olds, logic [1:0] news);
        for (int k = 0; k <= TOT; k++) begin
            if (k < TOT)
                push($sformatf("%s[%0d]", tag, k),
                     vec(1'b0, k < SET + RC, k < SET, (k < SET) ? olds : news, 1'b0, 1'b0));
            else
                push($sformatf("%s[%0d]", tag, k), vec(1'b1, 1'b0, 1'b0, news, 1'b1, 1'b1));
        end
    endtask

    task automatic push_selchg(string tag, logic [1:0] olds, logic [1:0] news);
        for (int k = 0; k <= 2 * SET; k++) begin
            if (k < SET)
                push($sformatf("%s[%0d]", tag, k), vec(1'b0, 1'b0, 1'b0, olds, 1'b0, 1'b0));
            else if (k < 2 * SET)
                push($sformatf("%s[%0d]", tag, k), vec(1'b0, 1'b0, 1'b0, news, 1'b0, 1'b0));
            else
                push($sformatf("%s[%0d]", tag, k), vec(1'b1, 1'b0, 1'b0, news, 1'b1, 1'b1));
        end
    endtask

    task automatic push_byp(string tag, logic [1:0] s);
        for (int k = 0; k <= 2 * SET; k++) begin
            if (k < SET)
                push($sformatf("%s[%0d]", tag, k), vec(1'b0, 1'b0, 1'b0, s, 1'b0, 1'b0));
            else if (k < 2 * SET)
                push($sformatf("%s[%0d]", tag, k), vec(1'b0, 1'b1, 1'b1, s, 1'b0, 1'b0));
            else
                push($sformatf("%s[%0d]", tag, k), vec(1'b1, 1'b1, 1'b1, s, 1'b1, 1'b0));
        end
    endtask

    // DLL_BYPASS / DLL_RST may only move while the downstream clock is gated.
    logic prev_byp, prev_rst, prev_en, prev_rstn;
    initial begin
        prev_byp  = 1'b1;
        prev_rst  = 1'b1;
        prev_en   = 1'b1;
        prev_rstn = 1'b0;
    end
    always begin
        @(posedge clk);
        #1;
        if (rst_n && prev_rstn && ((dll_bypass !== prev_byp) || (dll_rst !== prev_rst))) begin
            n_tests++;
            assert (clk_en === 1'b0 && prev_en === 1'b0) else begin
                n_fail++;
                $error("FAIL gate_on_toggle: observed clk_en %b/%b expected 0/0", prev_en, clk_en);
            end
        end
        prev_byp  = dll_bypass;
        prev_rst  = dll_rst;
        prev_en   = clk_en;
        prev_rstn = rst_n;
    end

    localparam logic [6:0] RST_VEC = 7'b1110010;

    initial begin
        rst_n      = 1'b0;
        cfg_vld    = 1'b0;
        cfg_bypass = 1'b0;
        cfg_sel    = 2'b00;
        #12;
        push("in_reset", RST_VEC);
        pop_check();
        #10;
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) push($sformatf("idle[%0d]", k), RST_VEC);
        run_sb();

        push_enable("en_10", 2'b00, 2'b10);
        hs(1'b0, 2'b10);
        run_sb();

        push_selchg("sel_11", 2'b10, 2'b11);
        hs(1'b0, 2'b11);
        run_sb();

        for (int k = 0; k < 4; k++)
            push($sformatf("noop[%0d]", k), vec(1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1));
        hs(1'b0, 2'b11);
        run_sb();

        push_byp("to_byp", 2'b11);
        hs(1'b1, 2'b00);
        run_sb();

        for (int k = 0; k < 2; k++)
            push($sformatf("byp_in_byp[%0d]", k), vec(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0));
        hs(1'b1, 2'b01);
        run_sb();

        // Request held valid with changing content while busy; only edge 41 may accept.
        push_enable("en_busy", 2'b01, 2'b10);
        push_selchg("busy_next", 2'b10, 2'b11);
        hs(1'b0, 2'b10);
        for (int i = 0; i <= TOT + 2 * SET + 1; i++) begin
            step_check();
            if (i <= TOT) begin
                cfg_vld = 1'b1;
                if (i % 2 == 0) begin
                    cfg_bypass = 1'b0;
                    cfg_sel    = 2'b11;
                end else begin
                    cfg_bypass = 1'b1;
                    cfg_sel    = 2'b00;
                end
            end else begin
                cfg_vld = 1'b0;
            end
        end
        run_sb();

        push_byp("to_byp2", 2'b11);
        hs(1'b1, 2'b00);
        run_sb();

        push_enable("en_pre_rst", 2'b11, 2'b10);
        hs(1'b0, 2'b10);
        for (int k = 0; k <= 20; k++) begin
            step_check();
            cfg_vld = 1'b0;
        end
        sb.delete();
        rst_n = 1'b0;
        #1;
        push("async_rst", RST_VEC);
        pop_check();
        for (int k = 0; k < 3; k++) push($sformatf("rst_hold[%0d]", k), RST_VEC);
        run_sb();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) push($sformatf("post_rst[%0d]", k), RST_VEC);
        run_sb();

        push_enable("en_after_rst", 2'b00, 2'b10);
        hs(1'b0, 2'b10);
        run_sb();

        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dll_clk_ctrl.md
# dll_clk_ctrl

Sequencing controller for the on-chip clock-multiplier DLL. It runs on the 50 MHz reference clock and owns the DLL's RST, BYPASS, S1 and S0 pins. It accepts clock-mode requests over a valid/ready handshake, applies the DLL reset and lock-wait sequence, and gates the downstream clock enable so the multiplied clock never glitches or goes X during a switch. It sits between the chip configuration registers and the DLL.

## Interface
Parameters:
- RST_CYC, default 4: cycles DLL_RST is held high before the lock wait.
- LOCK_CYC, default 32: fixed lock-wait cycles. The DLL has no lock output; this value must exceed its 20-step worst-case lock.
- SETTLE_CYC, default 2: gate-off and settle cycles around every output change.
- All three parameters must be ≥1. The counter width is clog2 of the largest parameter.

Ports:
- CLK  in  1  reference clock (DLL CLK input).
- RST_N  in  1  reset. One clock; reset is asynchronous and active-low.
- CFG_VLD  in  1  request valid.
- CFG_RDY  out  1  request ready.
- CFG_BYPASS  in  1  requested mode: 1 = bypass, 0 = DLL multiplied clock.
- CFG_SEL  in  2  requested multiplier {S1,S0}: 00 = ×2, 01 = ×4, 10 = ×8, 11 = ×10.
- DLL_RST  out  1  drives the DLL RST pin.
- DLL_BYPASS  out  1  drives the DLL BYPASS pin.
- DLL_S1, DLL_S0  out  1 each  drive the DLL select pins.
- CLK_EN  out  1  enable for the downstream clock gate.
- LOCKED  out  1  DLL clock selected and settled.

## Operation
- All outputs are registered and are a function of state plus the latched config. A single down-counter is loaded with N-1 on entering a timed state; the state exits when the counter reaches 0, so each timed state dwells exactly N cycles.
- States: BYP, GOFF, RSTH, LOCKW, SETL, RUN.
- Reset values: state = BYP, DLL_RST = 1, DLL_BYPASS = 1, {DLL_S1,DLL_S0} = 00, CLK_EN = 1, LOCKED = 0, CFG_RDY = 1. Latched target = {bypass = 1, sel = 00}.
- BYP: CFG_RDY = 1, CLK_EN = 1. A handshake (CFG_VLD & CFG_RDY) latches the config.
  - CFG_BYPASS = 1: stay in BYP; S pins take CFG_SEL on the next edge.
  - CFG_BYPASS = 0: go to GOFF with target = enable.
- GOFF (SETTLE_CYC): CLK_EN = 0, CFG_RDY = 0, LOCKED = 0. Exit by target:
  - enable → RSTH
  - sel change → SETL
  - bypass → SETL
- RSTH (RST_CYC): DLL_BYPASS = 0, DLL_RST = 1, S pins = latched sel. Next state LOCKW.
- LOCKW (LOCK_CYC): DLL_RST = 0. Next state SETL.
- SETL (SETTLE_CYC): CLK_EN remains 0. Entry updates depend on target:
  - sel change: S pins updated on entry.
  - bypass: DLL_BYPASS = 1 and DLL_RST = 1 on entry.
  - Exit goes to RUN (enable / sel change) or BYP (bypass).
- RUN: CLK_EN = 1, LOCKED = 1, CFG_RDY = 1. On a handshake:
  - CFG_BYPASS = 1 → GOFF (target bypass).
  - CFG_BYPASS = 0 with a different sel → GOFF (target sel change).
  - Same sel → accept as a no-op; outputs unchanged.
- Requests are accepted only in BYP and RUN. CFG_RDY = 0 in every other state, and CFG_* is ignored there.
- DLL_BYPASS and DLL_RST never change while CLK_EN = 1. This prevents the DLL's X output under reset from leaking downstream.
- RST_N low in any state: all outputs take their reset values immediately (asynchronously), the counter clears, and the latched target returns to bypass. On release, the block resumes in BYP.

## Timing
- Enable from BYP, with the handshake at edge 0 and default parameters:
  - Edge 0: CLK_EN = 0, CFG_RDY = 0.
  - Edge 2: DLL_BYPASS = 0.
  - Edge 6: DLL_RST = 0.
  - Edge 38: enter SETL.
  - Edge 40: LOCKED = 1, CLK_EN = 1, CFG_RDY = 1.
  - General latency: 2·SETTLE_CYC + RST_CYC + LOCK_CYC.
- Sel change in RUN, handshake at edge 0:
  - Edge 0: CLK_EN = 0, LOCKED = 0.
  - Edge 2: S pins = new sel.
  - Edge 4: RUN, CLK_EN = 1.
  - General latency: 2·SETTLE_CYC.
- Bypass from RUN, handshake at edge 0:
  - Edge 0: CLK_EN = 0, LOCKED = 0.
  - Edge 2: DLL_BYPASS = 1, DLL_RST = 1.
  - Edge 4: BYP, CLK_EN = 1, CFG_RDY = 1.
- Bypass request in BYP: single-cycle accept, no gating. CFG_RDY stays 1.
- CFG_VLD held high across a busy interval is not consumed until CFG_RDY rises. The first accept edge after that is the next handshake.

## Test plan
- Reset, idle 10 cycles: DLL_RST = 1, DLL_BYPASS = 1, CLK_EN = 1, LOCKED = 0, CFG_RDY = 1 throughout.
- Request {bypass = 0, sel = 10} from BYP: edges 2/6/40 as above. S pins = 10. LOCKED = 1 at edge 40. CLK_EN is 0 for exactly 40 cycles.
- In RUN with sel = 10, request sel = 11: CLK_EN low for 4 cycles. S pins change at edge 2. Then request sel = 11 again: no-op, CLK_EN stays 1.
- In RUN, request bypass: DLL_BYPASS = 1 at edge 2, BYP at edge 4. Assert that CLK_EN = 0 whenever DLL_BYPASS or DLL_RST toggles.
- CFG_VLD held high with alternating configs during LOCKW: no accept until edge 40. The next config is accepted at the first edge where CFG_RDY = 1.
- RST_N pulse mid-LOCKW (cycle 20): outputs return to reset values asynchronously. After release, the block sits in BYP with CFG_RDY = 1, and a new enable takes the full 40 cycles.
